pcie_send_cmd_issuer: RTL and testbench



---
 rtl/send_ctrl_pkg.sv | 20 ++
 rtl/send_req_fifo.sv | 56 +++++
 rtl/pcie_send_cmd_issuer.sv | 177 +++++++++++++++++
 tb/tb_pcie_send_cmd_issuer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/send_ctrl_pkg.sv
// Shared types and default constants for the PCIe send-command issuer.
package send_ctrl_pkg;

  localparam int SLOT_W_DEF     = 6;
  localparam int SLOT_SHIFT_DEF = 11;
  localparam int HOLDOFF_DEF    = 64;

  // Issuer FSM: IDLE pops the queue head, ISSUE waits for the port to be free.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issuer_state_t;

  // Decoded queue entry: the MSB of the slot index picks the MAC port.
  typedef struct packed {
    logic                  port;
    logic [SLOT_W_DEF-1:0] slot;
  } send_entry_t;

endpackage

// File: rtl/send_req_fifo.sv
// Single-clock request FIFO. A push into a full FIFO is accepted when a pop
// happens in the same cycle, so the queue can stay full while it drains.
module send_req_fifo
  import send_ctrl_pkg::*;
#(
  parameter int WIDTH = SLOT_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             pop_ok;
  logic             push_ok;

  // Flags and pointer advance; the extra pointer bit separates full from empty.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pcie_send_cmd_issuer.sv
// Queues slot requests from the PCIe send-control interface and issues
// cmd_send pulses to TSE transmit port 1 or 2 with a per-port holdoff.
// Optional feature macro: SEND_CMD_STATS_EN adds issued_cnt / dropped_cnt.
module pcie_send_cmd_issuer
  import send_ctrl_pkg::*;
#(
  parameter int                SLOT_W     = SLOT_W_DEF,
  parameter int                ADDR_W     = 25,
  parameter int                SLOT_SHIFT = SLOT_SHIFT_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 8,
  parameter int                HOLDOFF    = HOLDOFF_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ready_i,
  input  logic [SLOT_W-1:0] req_slot,
  input  logic              req_valid,
  output logic [ADDR_W-1:0] send1_start_ram_addr,
  output logic              send1_cmd_send,
  output logic [ADDR_W-1:0] send2_start_ram_addr,
  output logic              send2_cmd_send,
  output logic              drop_o,
  output logic              busy_o
`ifdef SEND_CMD_STATS_EN
  ,
  output logic [15:0]       issued_cnt,
  output logic [15:0]       dropped_cnt
`endif
);

  localparam int              CNT_W     = $clog2(HOLDOFF);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

  issuer_state_t     state_q, state_d;
  logic              pend_port_q, pend_port_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic [CNT_W-1:0]  cnt2_q, cnt2_d;
  logic              drop_q, drop_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [SLOT_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  send_entry_t       head_ent;
  logic              cmd1;
  logic              cmd2;

  // Slot-to-DDR address translation, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W_DEF-1:0] s);
    return BASE_ADDR + (ADDR_W'(s) << SLOT_SHIFT);
  endfunction

  send_req_fifo #(
    .WIDTH (SLOT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (req_slot),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Push acceptance and drop detection; a full FIFO still accepts when popping.
  always_comb begin
    head_ent  = '{port: fifo_dout[SLOT_W-1], slot: SLOT_W_DEF'(fifo_dout)};
    fifo_push = req_valid && (!fifo_full || fifo_pop);
    drop_d    = req_valid && !fifo_push;
  end

  // FSM next state: pop into the pending register, then wait for the port.
  always_comb begin
    state_d     = state_q;
    pend_port_d = pend_port_q;
    pend_addr_d = pend_addr_q;
    fifo_pop    = 1'b0;
    cmd1        = 1'b0;
    cmd2        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && ready_i) begin
          fifo_pop    = 1'b1;
          pend_port_d = head_ent.port;
          pend_addr_d = slot_addr(head_ent.slot);
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Head-of-line blocking: nothing behind this entry moves until it issues.
        if (ready_i) begin
          if (!pend_port_q && (cnt1_q == '0)) begin
            cmd1    = 1'b1;
            state_d = IDLE;
          end else if (pend_port_q && (cnt2_q == '0)) begin
            cmd2    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holdoff counters and address holding registers per port.
  always_comb begin
    cnt1_d  = cmd1 ? HOLD_LOAD : ((cnt1_q != '0) ? cnt1_q - 1'b1 : cnt1_q);
    cnt2_d  = cmd2 ? HOLD_LOAD : ((cnt2_q != '0) ? cnt2_q - 1'b1 : cnt2_q);
    addr1_d = cmd1 ? pend_addr_q : addr1_q;
    addr2_d = cmd2 ? pend_addr_q : addr2_q;
  end

  // Outputs: address is presented in the same cycle as its cmd_send pulse.
  always_comb begin
    send1_cmd_send       = cmd1;
    send2_cmd_send       = cmd2;
    send1_start_ram_addr = addr1_d;
    send2_start_ram_addr = addr2_d;
    drop_o               = drop_q;
    busy_o               = !fifo_empty || (state_q != IDLE);
  end

  // Issuer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pend_port_q <= 1'b0;
      pend_addr_q <= '0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_port_q <= pend_port_d;
      pend_addr_q <= pend_addr_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      drop_q      <= drop_d;
    end
  end

`ifdef SEND_CMD_STATS_EN
  logic [15:0] issued_q, issued_d;
  logic [15:0] dropped_q, dropped_d;

  // Saturating event counters.
  always_comb begin
    issued_d  = ((cmd1 || cmd2) && (issued_q != 16'hFFFF)) ? issued_q + 16'd1 : issued_q;
    dropped_d = (drop_q && (dropped_q != 16'hFFFF)) ? dropped_q + 16'd1 : dropped_q;
    issued_cnt  = issued_q;
    dropped_cnt = dropped_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      issued_q  <= issued_d;
      dropped_q <= dropped_d;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_send_cmd_issuer.sv
// Randomized and directed bench for pcie_send_cmd_issuer with a queue-based
// reference model (per-port last-issue times, a slot queue, a pending entry).
module tb_pcie_send_cmd_issuer;

  localparam int          SLOT_W     = 6;
  localparam int          ADDR_W     = 25;
  localparam int          SLOT_SHIFT = 11;
  localparam logic [24:0] BASE_ADDR  = 25'h000_0000;
  localparam int          DEPTH      = 8;
  localparam int          HOLDOFF    = 64;

  logic              clk;
  logic              reset_n;
  logic              ready_i;
  logic [SLOT_W-1:0] req_slot;
  logic              req_valid;
  logic [ADDR_W-1:0] send1_start_ram_addr;
  logic              send1_cmd_send;
  logic [ADDR_W-1:0] send2_start_ram_addr;
  logic              send2_cmd_send;
  logic              drop_o;
  logic              busy_o;

  pcie_send_cmd_issuer #(
    .SLOT_W     (SLOT_W),
    .ADDR_W     (ADDR_W),
    .SLOT_SHIFT (SLOT_SHIFT),
    .BASE_ADDR  (BASE_ADDR),
    .FIFO_DEPTH (DEPTH),
    .HOLDOFF    (HOLDOFF)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .ready_i              (ready_i),
    .req_slot             (req_slot),
    .req_valid            (req_valid),
    .send1_start_ram_addr (send1_start_ram_addr),
    .send1_cmd_send       (send1_cmd_send),
    .send2_start_ram_addr (send2_start_ram_addr),
    .send2_cmd_send       (send2_cmd_send),
    .drop_o               (drop_o),
    .busy_o               (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int obs_drops;

  // Reference model state
  logic [5:0]  m_q[$];
  logic        m_pend;
  logic [5:0]  m_pslot;
  logic [24:0] m_addr[2];
  int          m_last[2];
  logic        m_drop;

  // Observed command events
  int          ev_cyc[$];
  int          ev_port[$];
  logic [24:0] ev_addr[$];

  function automatic logic [24:0] addr_of(input logic [5:0] s);
    logic [24:0] a;
    a = 25'(s);
    return BASE_ADDR + (a << SLOT_SHIFT);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend    = 1'b0;
    m_pslot   = '0;
    m_addr[0] = '0;
    m_addr[1] = '0;
    m_last[0] = -100000;
    m_last[1] = -100000;
    m_drop    = 1'b0;
  endtask

  task automatic clear_ev();
    ev_cyc.delete();
    ev_port.delete();
    ev_addr.delete();
    obs_drops = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input logic v, input logic [5:0] s, input logic rdy);
    logic        ec[2];
    logic [24:0] ea[2];
    logic [24:0] pa;
    int          p;
    logic        busy_e;
    req_valid = v;
    req_slot  = s;
    ready_i   = rdy;
    #1;
    pa = addr_of(m_pslot);
    p  = int'(m_pslot[5]);
    for (int i = 0; i < 2; i++) begin
      ec[i] = m_pend && rdy && (p == i) && ((cyc - m_last[i]) >= HOLDOFF);
      ea[i] = ec[i] ? pa : m_addr[i];
    end
    busy_e = (m_q.size() > 0) || m_pend;

    n_checks++;
    if (send1_cmd_send !== ec[0]) begin
      n_fail++;
      $display("FAIL cmd1 cyc=%0d got=%b exp=%b", cyc, send1_cmd_send, ec[0]);
    end
    n_checks++;
    if (send2_cmd_send !== ec[1]) begin
      n_fail++;
      $display("FAIL cmd2 cyc=%0d got=%b exp=%b", cyc, send2_cmd_send, ec[1]);
    end
    n_checks++;
    if (send1_start_ram_addr !== ea[0]) begin
      n_fail++;
      $display("FAIL addr1 cyc=%0d got=%h exp=%h", cyc, send1_start_ram_addr, ea[0]);
    end
    n_checks++;
    if (send2_start_ram_addr !== ea[1]) begin
      n_fail++;
      $display("FAIL addr2 cyc=%0d got=%h exp=%h", cyc, send2_start_ram_addr, ea[1]);
    end
    n_checks++;
    if (drop_o !== m_drop) begin
      n_fail++;
      $display("FAIL drop cyc=%0d got=%b exp=%b", cyc, drop_o, m_drop);
    end
    n_checks++;
    if (busy_o !== busy_e) begin
      n_fail++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, busy_e);
    end
    n_checks++;
    if (send1_cmd_send === 1'b1 && send2_cmd_send === 1'b1) begin
      n_fail++;
      $display("FAIL onehot cyc=%0d got=11 exp=at most one", cyc);
    end

    if (send1_cmd_send === 1'b1) begin
      ev_cyc.push_back(cyc); ev_port.push_back(0); ev_addr.push_back(send1_start_ram_addr);
    end
    if (send2_cmd_send === 1'b1) begin
      ev_cyc.push_back(cyc); ev_port.push_back(1); ev_addr.push_back(send2_start_ram_addr);
    end
    if (drop_o === 1'b1) obs_drops++;

    // Model advance at the clock edge
    if (ec[0] || ec[1]) begin
      m_last[p] = cyc;
      m_addr[p] = pa;
      m_pend    = 1'b0;
    end else if (!m_pend && (m_q.size() > 0) && rdy) begin
      m_pslot = m_q.pop_front();
      m_pend  = 1'b1;
    end
    m_drop = 1'b0;
    if (v) begin
      if (m_q.size() < DEPTH) m_q.push_back(s);
      else m_drop = 1'b1;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 6'h00, rdy);
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if (send1_cmd_send !== 1'b0 || send2_cmd_send !== 1'b0 || drop_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ctrl got=%b%b%b%b exp=0000", tag, send1_cmd_send, send2_cmd_send, drop_o, busy_o);
    end
    n_checks++;
    if (send1_start_ram_addr !== 25'h0 || send2_start_ram_addr !== 25'h0) begin
      n_fail++;
      $display("FAIL %s_addr got=%h/%h exp=0/0", tag, send1_start_ram_addr, send2_start_ram_addr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    model_reset();
    cyc = 0;
    idle(3, 1'b1);
  endtask

  task automatic test_single();
    int k;
    idle(70, 1'b1);
    clear_ev();
    k = cyc;
    step(1'b1, 6'h03, 1'b1);
    idle(6, 1'b1);
    n_checks++;
    if (ev_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL single_count got=%0d exp=1", ev_cyc.size());
    end else begin
      n_checks++;
      if (ev_port[0] != 0 || ev_addr[0] !== 25'h0001800 || ev_cyc[0] != k + 2) begin
        n_fail++;
        $display("FAIL single_evt got=port%0d %h @%0d exp=port0 0001800 @%0d", ev_port[0], ev_addr[0], ev_cyc[0], k + 2);
      end
    end
  endtask

  task automatic test_two_ports();
    int k;
    idle(70, 1'b1);
    clear_ev();
    k = cyc;
    step(1'b1, 6'h21, 1'b1);
    step(1'b1, 6'h00, 1'b1);
    idle(8, 1'b1);
    n_checks++;
    if (ev_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL two_count got=%0d exp=2", ev_cyc.size());
    end else begin
      n_checks++;
      if (ev_port[0] != 1 || ev_addr[0] !== 25'h0010800 || ev_cyc[0] != k + 2) begin
        n_fail++;
        $display("FAIL two_first got=port%0d %h @%0d exp=port1 0010800 @%0d", ev_port[0], ev_addr[0], ev_cyc[0], k + 2);
      end
      n_checks++;
      if (ev_port[1] != 0 || ev_addr[1] !== 25'h0000000 || ev_cyc[1] != k + 4) begin
        n_fail++;
        $display("FAIL two_second got=port%0d %h @%0d exp=port0 0000000 @%0d", ev_port[1], ev_addr[1], ev_cyc[1], k + 4);
      end
    end
  endtask

  task automatic test_holdoff();
    idle(70, 1'b1);
    clear_ev();
    step(1'b1, 6'h05, 1'b1);
    step(1'b1, 6'h06, 1'b1);
    step(1'b1, 6'h22, 1'b1);
    idle(80, 1'b1);
    n_checks++;
    if (ev_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL holdoff_count got=%0d exp=3", ev_cyc.size());
    end else begin
      n_checks++;
      if (ev_cyc[1] - ev_cyc[0] != 64 || ev_port[1] != 0) begin
        n_fail++;
        $display("FAIL holdoff_gap got=%0d exp=64", ev_cyc[1] - ev_cyc[0]);
      end
      n_checks++;
      if (ev_port[2] != 1 || ev_cyc[2] != ev_cyc[1] + 2) begin
        n_fail++;
        $display("FAIL holdoff_hol got=port%0d @%0d exp=port1 @%0d", ev_port[2], ev_cyc[2], ev_cyc[1] + 2);
      end
    end
  endtask

  task automatic test_full_drop();
    logic [5:0] sl[9];
    sl = '{6'h01, 6'h22, 6'h03, 6'h24, 6'h05, 6'h26, 6'h07, 6'h28, 6'h09};
    idle(70, 1'b1);
    clear_ev();
    for (int i = 0; i < 9; i++) step(1'b1, sl[i], 1'b0);
    idle(5, 1'b0);
    n_checks++;
    if (obs_drops != 1 || ev_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL full_drop got=drops%0d cmds%0d exp=drops1 cmds0", obs_drops, ev_cyc.size());
    end
    idle(300, 1'b1);
    n_checks++;
    if (ev_cyc.size() != 8) begin
      n_fail++;
      $display("FAIL full_drain got=%0d exp=8", ev_cyc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (ev_addr[i] !== addr_of(sl[i]) || ev_port[i] != int'(sl[i][5])) begin
          n_fail++;
          $display("FAIL full_order[%0d] got=%h exp=%h", i, ev_addr[i], addr_of(sl[i]));
        end
      end
    end
  endtask

  task automatic test_push_pop_full();
    logic [5:0] sl[10];
    for (int i = 0; i < 10; i++) sl[i] = 6'((i * 13 + 2) & 63);
    idle(70, 1'b1);
    clear_ev();
    for (int i = 0; i < 8; i++) step(1'b1, sl[i], 1'b0);
    step(1'b1, sl[8], 1'b1);
    step(1'b1, sl[9], 1'b1);
    n_checks++;
    if (obs_drops != 0) begin
      n_fail++;
      $display("FAIL pushpop_nodrop got=%0d exp=0", obs_drops);
    end
    idle(600, 1'b1);
    n_checks++;
    if (obs_drops != 1 || ev_cyc.size() != 9) begin
      n_fail++;
      $display("FAIL pushpop_full got=drops%0d cmds%0d exp=drops1 cmds9", obs_drops, ev_cyc.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (ev_addr[i] !== addr_of(sl[i])) begin
          n_fail++;
          $display("FAIL pushpop_order[%0d] got=%h exp=%h", i, ev_addr[i], addr_of(sl[i]));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, 6'($urandom_range(0, 63)),
           ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    idle(70, 1'b1);
    step(1'b1, 6'h01, 1'b1);
    step(1'b1, 6'h02, 1'b1);
    step(1'b1, 6'h03, 1'b1);
    step(1'b1, 6'h21, 1'b1);
    step(1'b1, 6'h04, 1'b1);
    idle(8, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    clear_ev();
    idle(150, 1'b1);
    n_checks++;
    if (ev_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_cmds got=%0d exp=0", ev_cyc.size());
    end
  endtask

  initial begin
    clk       = 1'b0;
    reset_n   = 1'b0;
    ready_i   = 1'b0;
    req_slot  = '0;
    req_valid = 1'b0;
    obs_drops = 0;
    model_reset();
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_two_ports();
    test_holdoff();
    test_full_drop();
    test_push_pop_full();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
